// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer for three 8-bit working registers and a shared add/multiply datapath.
// Executes one {dst, src, imm, op} instruction at a time, accepted over a valid/ready handshake.
module alu_sequencer #(
    parameter int W = 8
) (
    input  logic         ck,
    input  logic         clr_n,
    input  logic [12:0]  instr,
    input  logic         ci,
    input  logic         instr_valid,
    output logic         instr_ready,
    output logic         done,
    output logic [W-1:0] result,
    output logic         carry,
    output logic [W-1:0] r0,
    output logic [W-1:0] r1,
    output logic [W-1:0] r2
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        EXEC = 3'd2,
        WB   = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t         state_r;
    state_t         state_nxt_s;
    logic [12:0]    ir_r;
    logic           ci_r;
    logic [W-1:0]   a_r;
    logic [W-1:0]   b_r;
    logic [W-1:0]   acc_r;
    logic           cflag_r;
    logic [2:0]     cnt_r;

    logic [1:0]     dst_s;
    logic [1:0]     src_s;
    logic [W-1:0]   imm_s;
    logic           op_s;
    logic [W-1:0]   src_val_s;
    logic [W:0]     sum_s;
    logic [W-1:0]   pp_s;

    assign dst_s = ir_r[12:11];
    assign src_s = ir_r[10:9];
    assign imm_s = ir_r[8:1];
    assign op_s  = ir_r[0];

    // Handshake and completion flags are pure state decodes.
    assign instr_ready = (state_r == IDLE);
    assign done        = (state_r == DONE);

    // Source operand select; src = 11 reads as zero.
    always_comb begin
        src_val_s = {W{1'b0}};
        case (src_s)
            2'b00:   src_val_s = r0;
            2'b01:   src_val_s = r1;
            2'b10:   src_val_s = r2;
            default: src_val_s = {W{1'b0}};
        endcase
    end

    // Adder sum and the shift-add partial product for the current multiplier bit.
    always_comb begin
        sum_s = {1'b0, a_r} + {1'b0, b_r} + {{W{1'b0}}, ci_r};
        pp_s  = {W{1'b0}};
        if (b_r[cnt_r]) begin
            pp_s = a_r << cnt_r;
        end else begin
            pp_s = {W{1'b0}};
        end
    end

    // State register.
    always_ff @(posedge ck) begin
        if (!clr_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; add spends one cycle in EXEC, mul spends eight.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (instr_valid) begin
                    state_nxt_s = READ;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            READ: state_nxt_s = EXEC;
            EXEC: begin
                if (op_s || (cnt_r == 3'd7)) begin
                    state_nxt_s = WB;
                end else begin
                    state_nxt_s = EXEC;
                end
            end
            WB:      state_nxt_s = DONE;
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Datapath: instruction capture, operand latch, execute, write-back.
    always_ff @(posedge ck) begin
        if (!clr_n) begin
            ir_r    <= 13'd0;
            ci_r    <= 1'b0;
            a_r     <= {W{1'b0}};
            b_r     <= {W{1'b0}};
            acc_r   <= {W{1'b0}};
            cflag_r <= 1'b0;
            cnt_r   <= 3'd0;
            result  <= {W{1'b0}};
            carry   <= 1'b0;
            r0      <= {W{1'b0}};
            r1      <= {W{1'b0}};
            r2      <= {W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (instr_valid) begin
                        ir_r <= instr;
                        ci_r <= ci;
                    end
                end
                READ: begin
                    a_r   <= src_val_s;
                    b_r   <= imm_s;
                    cnt_r <= 3'd0;
                    if (!op_s) begin
                        acc_r <= {W{1'b0}};
                    end
                end
                EXEC: begin
                    if (op_s) begin
                        acc_r   <= sum_s[W-1:0];
                        cflag_r <= sum_s[W];
                    end else begin
                        acc_r <= acc_r + pp_s;
                        cnt_r <= cnt_r + 3'd1;
                    end
                end
                WB: begin
                    result <= acc_r;
                    carry  <= cflag_r;
                    case (dst_s)
                        2'b00:   r0 <= acc_r;
                        2'b01:   r1 <= acc_r;
                        2'b10:   r2 <= acc_r;
                        default: begin end
                    endcase
                end
                default: begin end
            endcase
        end
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle sequencer that owns the three 8-bit working registers (R0–R2) and the shared adder/multiplier datapath, and executes one 13-bit instruction word at a time. Instructions arrive over a valid/ready handshake, using the same word format as the DIP-switch front panel. Each instruction reads one source register, combines it with an 8-bit immediate by add or multiply, and writes one destination register. It replaces manual clocking of the register/decoder path with a controlled FSM, so the bench or a future instruction ROM can drive the datapath.

## Interface
Parameters:
- W, 8, datapath width; fixed at 8 for this design (the instruction format assumes it).

Ports:
- ck  in  1  clock; all state changes on the rising edge.
- clr_n  in  1  reset, synchronous, active-low.
- instr  in  13  instruction word {dst[1:0], src[1:0], imm[7:0], op}.
  - op: 1 = add, 0 = mul.
  - src/dst: 00 = R0, 01 = R1, 10 = R2, 11 = none.
- ci  in  1  adder carry-in; captured together with instr.
- instr_valid  in  1  instr and ci are valid.
- instr_ready  out  1  high only in IDLE.
- done  out  1  one-cycle pulse; the destination register already holds the new value.
- result  out  8  last computed result (held between instructions).
- carry  out  1  carry-out of the last add.
- r0, r1, r2  out  8 each  register contents (LED taps).

## Operation
- States: IDLE, READ, EXEC, WB, DONE.
- IDLE:
  - instr_ready = 1.
  - On instr_valid & instr_ready: capture instr into IR and ci into CI, then go to READ.
- READ: latch operand A = register[src] (A = 0 when src = 11); B = IR.imm. Go to EXEC.
- EXEC, add (op = 1):
  - 9-bit sum = A + B + CI.
  - acc ← sum[7:0], cflag ← sum[8].
  - One cycle, then WB.
- EXEC, mul (op = 0):
  - Iterative shift-add, LSB first, over 8 cycles with a 3-bit counter.
  - Each cycle: if B[i], acc ← acc + (A << i), truncated to 8 bits.
  - Final acc = (A × B) mod 256; cflag is unchanged.
  - After the counter reaches 7, go to WB.
- WB:
  - result ← acc; carry ← cflag.
  - If dst ≠ 11, register[dst] ← acc. dst = 11 writes nothing.
  - Go to DONE.
- DONE: done = 1 for this cycle only. Go to IDLE.
- src == dst is legal: the old value is read in READ, the new value is written in WB.
- instr_valid while not in IDLE is ignored. instr is not sampled, and the requester must hold it until accepted.
- Only one instruction is in flight; there is no pipelining.

## Timing
Acceptance edge = E0.
- Add:
  - READ after E0, EXEC after E1, WB after E2.
  - Register write and result update at E3; done high between E3 and E4.
  - instr_ready high again after E4; earliest next acceptance is E5.
- Mul: EXEC spans E2..E9; write at E10; done high between E10 and E11; ready after E11.
- Reset (clr_n low at a rising edge):
  - state = IDLE.
  - R0 = R1 = R2 = 0, result = 0, carry = 0, acc = 0, IR = 0, done = 0.
  - instr_ready = 1 in the first cycle after reset is released.
- Reset takes priority over every other action, including an instruction mid-execution. A mid-mul reset abandons the operation: no register write and no done.
- instr_valid asserted together with clr_n low: the instruction is not accepted.
- All outputs are driven from registers or decoded from state. There is no combinational path from instr or instr_valid to any output.

## Test plan
- Reset, then instr {00,11,0x05,1}, ci = 0:
  - R0 = 0x05, result = 0x05, carry = 0.
  - done pulses exactly 4 edges after acceptance.
  - instr_ready is low from E0 through E4.
- Preload R1 = 0xF0 via {01,11,0xF0,1}, then {10,01,0x20,1} with ci = 1:
  - R2 = 0x11, carry = 1.
  - R1 is unchanged at 0xF0.
- R0 = 0x0D, then mul {01,00,0x0B,0}:
  - R1 = 0x8F (13 × 11 = 143).
  - done 11 edges after acceptance; carry unchanged.
  - Then {01,01,0x02,0}: R1 = 0x1E (286 mod 256, overflow truncated; also covers src == dst).
- dst = 11 instruction {11,00,0x01,1} with R0 = 0x7F:
  - result = 0x80, done pulses.
  - R0–R2 all unchanged.
- Reset mid-mul: drop clr_n at E5 of a mul targeting R2 = 0x33:
  - R2 = 0, no done pulse.
  - instr_ready = 1 the cycle after release.
- instr_valid held high continuously with changing instr:
  - Only the words present at IDLE acceptance edges execute.
  - Words presented while busy are never executed.
